// File: rtl/nco_freq_ctrl.sv
// NCO frequency-word controller: shadowed host writes, one-cycle commit to all mixers,
// and a phase-sync sequence that zeroes every word. Optional macro: NCO_SYNC_ON_COMMIT_EN.
module nco_freq_ctrl #(
    parameter int NUM_RX      = 4,
    parameter int WF          = 32,
    parameter int ADDR_W      = 3,
    parameter int SYNC_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic signed [WF-1:0]  cmd_freq,
    input  logic                  cmd_commit,
    input  logic                  sync_req,
    output logic                  sync_busy,
    output logic                  addr_err,
    output logic [NUM_RX*WF-1:0]  freq_out
);

    localparam int CNT_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SYNC_CYCLES - 1);
    localparam logic [ADDR_W:0]   NUM_RX_EXT = (ADDR_W + 1)'(NUM_RX);

    typedef enum logic [1:0] {IDLE, ZERO, RESTORE} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                commit_pend, pend_nxt;
    logic                sync_go;
    logic                apply;
    logic                zero_out;
    logic                wr_fire;
    logic                wr_in_range;

    logic signed [WF-1:0] shadow     [NUM_RX];
    logic signed [WF-1:0] shadow_nxt [NUM_RX];
    logic signed [WF-1:0] active     [NUM_RX];
    logic signed [WF-1:0] active_nxt [NUM_RX];
    logic [NUM_RX-1:0]    dirty, dirty_wr, dirty_nxt;

    assign wr_fire     = cmd_valid & cmd_ready;
    assign wr_in_range = ({1'b0, cmd_addr} < NUM_RX_EXT);

    // A commit in IDLE either copies immediately or, with sync-on-commit, starts a sync.
    always_comb begin
`ifdef NCO_SYNC_ON_COMMIT_EN
        sync_go = sync_req | cmd_commit;
`else
        sync_go = sync_req;
`endif
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ZERO) ? cnt + CNT_W'(1) : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sync_go) state_nxt = ZERO;
            ZERO:    if (cnt == CNT_LAST) state_nxt = RESTORE;
            RESTORE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        apply    = 1'b0;
        pend_nxt = commit_pend;
        zero_out = 1'b0;
        case (state)
            IDLE: begin
                apply    = cmd_commit & ~sync_go;
                pend_nxt = cmd_commit & sync_go;
            end
            ZERO: begin
                zero_out = 1'b1;
                pend_nxt = commit_pend | cmd_commit;
            end
            RESTORE: begin
                apply    = commit_pend | cmd_commit;
                pend_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // Merge this cycle's write first so a same-cycle commit picks it up.
    always_comb begin
        for (int k = 0; k < NUM_RX; k++) begin
            shadow_nxt[k] = shadow[k];
            dirty_wr[k]   = dirty[k];
            if (wr_fire && wr_in_range && cmd_addr == ADDR_W'(k)) begin
                shadow_nxt[k] = cmd_freq;
                dirty_wr[k]   = 1'b1;
            end
            active_nxt[k] = (apply && dirty_wr[k]) ? shadow_nxt[k] : active[k];
        end
        dirty_nxt = apply ? '0 : dirty_wr;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_RX; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            dirty       <= '0;
            commit_pend <= 1'b0;
            freq_out    <= '0;
            cmd_ready   <= 1'b1;
            sync_busy   <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_RX; k++) begin
                shadow[k] <= shadow_nxt[k];
                active[k] <= active_nxt[k];
                freq_out[k*WF +: WF] <= zero_out ? '0 : active_nxt[k];
            end
            dirty       <= dirty_nxt;
            commit_pend <= pend_nxt;
            cmd_ready   <= (state_nxt == IDLE);
            sync_busy   <= (state_nxt != IDLE);
            addr_err    <= wr_fire & ~wr_in_range;
        end
    end

endmodule

// File: tb/tb_nco_freq_ctrl.sv
// Scoreboard bench for nco_freq_ctrl: stimulus queues expected snapshots per cycle,
// a negedge monitor pops and compares them.
module tb_nco_freq_ctrl;

    localparam int NUM_RX = 4;
    localparam int WF     = 32;
    localparam int ADDR_W = 3;
    localparam int SC     = 2;

    logic                 clock = 1'b0;
    logic                 rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [WF-1:0]        cmd_freq;
    logic                 cmd_commit;
    logic                 sync_req;
    logic                 sync_busy;
    logic                 addr_err;
    logic [NUM_RX*WF-1:0] freq_out;

    nco_freq_ctrl #(.NUM_RX(NUM_RX), .WF(WF), .ADDR_W(ADDR_W), .SYNC_CYCLES(SC)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_freq   (cmd_freq),
        .cmd_commit (cmd_commit),
        .sync_req   (sync_req),
        .sync_busy  (sync_busy),
        .addr_err   (addr_err),
        .freq_out   (freq_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned          cyc;
        logic [NUM_RX*WF-1:0] f;
        logic                 rdy;
        logic                 busy;
        logic                 aerr;
        string                name;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (cur.cyc != cyc || freq_out !== cur.f || cmd_ready !== cur.rdy ||
                sync_busy !== cur.busy || addr_err !== cur.aerr) begin
                errors++;
                $display("FAIL %s cyc %0d: actual f=%h rdy=%b busy=%b err=%b, required f=%h rdy=%b busy=%b err=%b",
                         cur.name, cyc, freq_out, cmd_ready, sync_busy, addr_err,
                         cur.f, cur.rdy, cur.busy, cur.aerr);
            end
        end
    end

    function automatic logic [NUM_RX*WF-1:0] fv(logic [31:0] c0, logic [31:0] c1,
                                                 logic [31:0] c2, logic [31:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(int d, logic [NUM_RX*WF-1:0] f, logic r, logic b, logic ae, string n);
        exp_t e;
        e.cyc  = cyc + d;
        e.f    = f;
        e.rdy  = r;
        e.busy = b;
        e.aerr = ae;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic drive(logic v, logic [ADDR_W-1:0] a, logic [WF-1:0] f, logic c, logic s);
        cmd_valid  = v;
        cmd_addr   = a;
        cmd_freq   = f;
        cmd_commit = c;
        sync_req   = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        step();
        step();
        chk(0, '0, 1, 0, 0, "reset");
        rst_n = 1'b1;

`ifndef NCO_SYNC_ON_COMMIT_EN
        // basic write then commit
        drive(1, 1, 32'h0100_0000, 0, 0);
        step();
        chk(0, '0, 1, 0, 0, "t1_before_commit");
        drive(0, 0, 0, 1, 0);
        step();
        chk(0, fv(0, 32'h0100_0000, 0, 0), 1, 0, 0, "t1_commit");

        // last write wins, clean channel holds
        drive(1, 2, 9, 1, 0);
        step();
        chk(0, fv(0, 32'h0100_0000, 9, 0), 1, 0, 0, "t2_ch2_set");
        drive(1, 0, 5, 0, 0);
        step();
        drive(1, 0, 7, 0, 0);
        step();
        chk(0, fv(0, 32'h0100_0000, 9, 0), 1, 0, 0, "t2_hold");
        drive(0, 0, 0, 1, 0);
        step();
        chk(0, fv(7, 32'h0100_0000, 9, 0), 1, 0, 0, "t2_last_wins");

        // write + commit same cycle
        drive(1, 3, 32'h1234, 1, 0);
        step();
        chk(0, fv(7, 32'h0100_0000, 9, 32'h1234), 1, 0, 0, "t3_same_cycle");

        // sync sequence with restore and stalled write
        drive(1, 0, 1, 0, 0); step();
        drive(1, 1, 2, 0, 0); step();
        drive(1, 2, 3, 0, 0); step();
        drive(1, 3, 4, 1, 0); step();
        chk(0, fv(1, 2, 3, 4), 1, 0, 0, "t4_loaded");
        drive(0, 0, 0, 0, 1);
        step();
        chk(0, fv(1, 2, 3, 4), 0, 1, 0, "t4_zero_entry");
        drive(1, 0, 32'h77, 0, 0);
        step();
        chk(0, '0, 0, 1, 0, "t4_zero1");
        step();
        chk(0, '0, 0, 1, 0, "t4_zero2");
        step();
        chk(0, fv(1, 2, 3, 4), 1, 0, 0, "t4_restored");
        step();
        drive(0, 0, 0, 1, 0);
        step();
        chk(0, fv(32'h77, 2, 3, 4), 1, 0, 0, "t4_stalled_write");

        // commit during ZERO applied on restore
        drive(1, 2, 32'h55, 0, 0);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        chk(0, fv(32'h77, 2, 3, 4), 0, 1, 0, "t5_zero_entry");
        drive(0, 0, 0, 1, 0);
        step();
        chk(0, '0, 0, 1, 0, "t5_zero1");
        drive(0, 0, 0, 0, 0);
        step();
        chk(0, '0, 0, 1, 0, "t5_zero2");
        step();
        chk(0, fv(32'h77, 2, 32'h55, 4), 1, 0, 0, "t5_restore_commit");

        // out-of-range address
        drive(1, 5, 32'hdead, 0, 0);
        step();
        chk(0, fv(32'h77, 2, 32'h55, 4), 1, 0, 1, "t6_addr_err");
        drive(0, 0, 0, 1, 0);
        step();
        chk(0, fv(32'h77, 2, 32'h55, 4), 1, 0, 0, "t6_no_change");
        drive(0, 0, 0, 0, 0);
`else
        drive(1, 0, 3, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
`endif

        // reset during ZERO
        drive(0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        chk(0, '0, 0, 1, 0, "t7_in_zero");
        step();
        rst_n = 1'b0;
        #1;
        chk(0, '0, 1, 0, 0, "t7_reset_mid_zero");
        step();
        rst_n = 1'b1;
        step();
        chk(0, '0, 1, 0, 0, "t7_after_reset");

`ifndef NCO_SYNC_ON_COMMIT_EN
        drive(1, 1, 8, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk(0, fv(0, 8, 0, 0), 1, 0, 0, "t8_commit_after_reset");
`else
        drive(1, 1, 8, 1, 0);
        step();
        drive(0, 0, 0, 0, 0);
        chk(0, '0, 0, 1, 0, "sc_entry");
        step();
        chk(0, '0, 0, 1, 0, "sc_zero1");
        step();
        chk(0, '0, 0, 1, 0, "sc_zero2");
        step();
        chk(0, fv(0, 8, 0, 0), 1, 0, 0, "sc_applied");
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            $display("FAIL drain: actual %0d pending, required 0", sb.size());
            errors += sb.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
